// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: double-buffered hex display, one active-low digit per slot.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero nibble.
module seg7_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic                    blank,
  output logic                    wr_ack,
  output logic                    frame_done,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt_r;
  logic [IW-1:0]           idx_r;
  logic [4*NUM_DIGITS-1:0] disp_r;
  logic [4*NUM_DIGITS-1:0] pend_r;
  logic                    pend_flag_r;
  logic                    wr_ack_r;
  logic                    frame_done_r;
  logic [6:0]              seg_r;
  logic [NUM_DIGITS-1:0]   an_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [3:0]              nib_s;
  logic                    dark_s;
  logic [6:0]              seg_s;
  logic [NUM_DIGITS-1:0]   an_s;

  // Active-low glyph table, bit0 = a .. bit6 = g
  function automatic logic [6:0] seg_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign tick_s = (cnt_r == CW'(REFRESH_DIV - 1));
  assign wrap_s = tick_s && (idx_r == IW'(NUM_DIGITS - 1));

  // Select the current nibble and decide whether this slot is dark
  always_comb begin
    nib_s  = 4'h0;
    dark_s = blank;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == IW'(i)) begin
        nib_s = disp_r[4*i +: 4];
      end else begin
        nib_s = nib_s;
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic [IW-1:0] msd_v;
      msd_v = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        if (disp_r[4*i +: 4] != 4'h0) begin
          msd_v = IW'(i);
        end else begin
          msd_v = msd_v;
        end
      end
      // digit 0 is never above msd, so a zero value still shows one "0"
      if (idx_r > msd_v) begin
        dark_s = 1'b1;
      end else begin
        dark_s = blank;
      end
    end
`endif
  end

  // Next registered digit enable and segment pattern
  always_comb begin
    an_s  = '1;
    seg_s = 7'h7F;
    if (dark_s) begin
      an_s  = '1;
      seg_s = 7'h7F;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_s[i] = (idx_r != IW'(i));
      end
      seg_s = seg_glyph(nib_s);
    end
  end

  // Scan counters, double buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      idx_r        <= '0;
      disp_r       <= '0;
      pend_r       <= '0;
      pend_flag_r  <= 1'b0;
      wr_ack_r     <= 1'b0;
      frame_done_r <= 1'b0;
      seg_r        <= 7'h7F;
      an_r         <= '1;
    end else begin
      if (tick_s) begin
        cnt_r <= '0;
        idx_r <= wrap_s ? '0 : idx_r + IW'(1);
      end else begin
        cnt_r <= cnt_r + CW'(1);
        idx_r <= idx_r;
      end
      frame_done_r <= wrap_s;
      wr_ack_r     <= wrap_s && pend_flag_r;
      if (wrap_s && pend_flag_r) begin
        disp_r <= pend_r;
      end else begin
        disp_r <= disp_r;
      end
      // A write on the wrap tick stays pending; the older value loads first
      if (wr_en) begin
        pend_r      <= wr_data;
        pend_flag_r <= 1'b1;
      end else if (wrap_s) begin
        pend_flag_r <= 1'b0;
      end else begin
        pend_flag_r <= pend_flag_r;
      end
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

  assign wr_ack     = wr_ack_r;
  assign frame_done = frame_done_r;
  assign seg        = seg_r;
  assign an         = an_r;

endmodule
